ext_mem_stream_tx: RTL and testbench

- Transmitter for the chip's a/b operand stream interface.
- Reads a contiguous region of external memory through the pseudo-2-port read port and unpacks each EXT_MEM_WIDTH word into IO_DATA_WIDTH elements, lower element first.
- Drives the elements out over a valid/ready stream with a zero flag, as consumed by the a_input/b_input ports.
- Used as the feeder in front of top_chip's operand inputs.

---
 rtl/ext_mem_stream_tx_if.sv | 23 ++
 rtl/ext_mem_stream_tx.sv | 88 ++++++++
 tb/tb_ext_mem_stream_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ext_mem_stream_tx_if.sv
// ext_mem_stream_tx_if: external-memory read port plus element stream handshake.
interface ext_mem_stream_tx_if #(
  parameter int IO_DATA_WIDTH  = 16,
  parameter int EXT_MEM_WIDTH  = 32,
  parameter int EXT_MEM_HEIGHT = 1 << 20
);
  localparam int AW = $clog2(EXT_MEM_HEIGHT);
  logic [AW-1:0]            ext_mem_read_addr;
  logic                     ext_mem_read_en;
  logic [EXT_MEM_WIDTH-1:0] ext_mem_qout;
  logic [IO_DATA_WIDTH-1:0] stream_data;
  logic                     stream_zero_flag;
  logic                     stream_valid;
  logic                     stream_ready;
  modport master (
    output ext_mem_read_addr, ext_mem_read_en, stream_data, stream_zero_flag, stream_valid,
    input  ext_mem_qout, stream_ready
  );
  modport slave (
    input  ext_mem_read_addr, ext_mem_read_en, stream_data, stream_zero_flag, stream_valid,
    output ext_mem_qout, stream_ready
  );
endinterface

// File: rtl/ext_mem_stream_tx.sv
// ext_mem_stream_tx: reads a memory region and streams it out as IO_DATA_WIDTH elements, low element first.
module ext_mem_stream_tx #(
   parameter int IO_DATA_WIDTH  = 16,
   parameter int EXT_MEM_WIDTH  = 32,
   parameter int EXT_MEM_HEIGHT = 1 << 20,
   parameter int LEN_WIDTH      = 24,
   localparam int AW            = $clog2(EXT_MEM_HEIGHT)
) (
   input  logic                 clk,
   input  logic                 arst_n_in,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [LEN_WIDTH-1:0] length,
   output logic                 running,
   output logic                 done,
   ext_mem_stream_tx_if.master  bus
);
   localparam int PACK = EXT_MEM_WIDTH / IO_DATA_WIDTH;
   localparam int KW   = PACK > 1 ? $clog2(PACK) : 1;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t                 state, state_nx;
   logic [AW-1:0]          base_q;
   logic [LEN_WIDTH-1:0]   len_q, total_words, words_issued, elem_cnt;
   logic [LEN_WIDTH:0]     words_ceil;
   logic [KW-1:0]          k;
   logic [EXT_MEM_WIDTH-1:0] fifo [2];
   logic                   wr_ptr, rd_ptr, rvalid;
   logic [1:0]             count;
   logic [EXT_MEM_WIDTH-1:0] head;
   logic                   hs, last, pop, rd_go;
   assign words_ceil = ({1'b0, length} + (LEN_WIDTH+1)'(PACK - 1)) / (LEN_WIDTH+1)'(PACK);
   // A word returning from memory is visible straight away when the FIFO is empty.
   always_comb begin
      head                  = count != 2'd0 ? fifo[rd_ptr] : bus.ext_mem_qout;
      bus.stream_valid      = state == RUN && (count != 2'd0 || rvalid);
      bus.stream_data       = bus.stream_valid ? head[int'(k)*IO_DATA_WIDTH +: IO_DATA_WIDTH] : '0;
      bus.stream_zero_flag  = bus.stream_valid && bus.stream_data == '0;
      hs                    = bus.stream_valid && bus.stream_ready;
      last                  = elem_cnt == len_q - LEN_WIDTH'(1);
      pop                   = hs && (k == KW'(PACK - 1) || last);
      rd_go                 = state == RUN && words_issued < total_words && (count + {1'b0, rvalid}) < 2'd2;
      bus.ext_mem_read_en   = rd_go;
      bus.ext_mem_read_addr = rd_go ? base_q + AW'(words_issued) : '0;
      running               = state == RUN;
      done                  = state == FIN;
      state_nx              = state == IDLE ? (start ? (length != '0 ? RUN : FIN) : IDLE) :
                              state == RUN  ? (hs && last ? FIN : RUN) : IDLE;
   end
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state        <= IDLE;
         base_q       <= '0;
         len_q        <= '0;
         total_words  <= '0;
         words_issued <= '0;
         elem_cnt     <= '0;
         k            <= '0;
         fifo[0]      <= '0;
         fifo[1]      <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= '0;
         rvalid       <= 1'b0;
      end else begin
         state  <= state_nx;
         rvalid <= rd_go;
         if (state == IDLE && start) begin
            base_q       <= base_addr;
            len_q        <= length;
            total_words  <= words_ceil[LEN_WIDTH-1:0];
            words_issued <= '0;
            elem_cnt     <= '0;
            k            <= '0;
         end
         if (rd_go) words_issued <= words_issued + 1'b1;
         if (hs) begin
            elem_cnt <= elem_cnt + 1'b1;
            k        <= pop ? '0 : k + 1'b1;
         end
         if (rvalid) begin
            fifo[wr_ptr] <= bus.ext_mem_qout;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, rvalid} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_ext_mem_stream_tx.sv
// tb_ext_mem_stream_tx: randomized transfers checked against an element-list model of memory.
module tb_ext_mem_stream_tx;
   localparam int IOW = 16, MW = 32, H = 1 << 20, AW = 20, LW = 24, PACK = MW / IOW;
   logic clk = 1'b0, arst_n = 1'b0, start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic running, done;
   logic [MW-1:0] mem [int];
   int n_cmp = 0, n_bad = 0;
   ext_mem_stream_tx_if #(.IO_DATA_WIDTH(IOW), .EXT_MEM_WIDTH(MW), .EXT_MEM_HEIGHT(H)) bus ();
   ext_mem_stream_tx #(.IO_DATA_WIDTH(IOW), .EXT_MEM_WIDTH(MW), .EXT_MEM_HEIGHT(H), .LEN_WIDTH(LW)) dut (
      .clk(clk), .arst_n_in(arst_n), .start(start), .base_addr(base_addr), .length(length),
      .running(running), .done(done), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (bus.ext_mem_read_en)
         bus.ext_mem_qout <= mem.exists(int'(bus.ext_mem_read_addr)) ? mem[int'(bus.ext_mem_read_addr)] : '0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [IOW-1:0] ref_elem(input int b, input int i);
      logic [MW-1:0] w;
      int a;
      a = (b + i / PACK) % H;
      w = mem.exists(a) ? mem[a] : '0;
      return w[(i % PACK)*IOW +: IOW];
   endfunction
   task automatic fill(input int b, input int nwords);
      logic [MW-1:0] r;
      for (int w = 0; w < nwords; w++) begin
         r = $urandom;
         if ($urandom_range(3) == 0) r[15:0] = '0;
         if ($urandom_range(3) == 0) r[31:16] = '0;
         mem[(b + w) % H] = r;
      end
   endtask
   function automatic logic rdy(input int mode, input int cyc);
      return mode == 0 ? 1'b1 : mode == 1 ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(1));
   endfunction
   task automatic run_xfer(input int b, input int len, input int rmode, input int abort_at, input bit poke);
      int hs = 0, reads = 0, dones = 0, first_valid = -1, last_hs = -1, done_cyc = -1;
      int bound = len * 4 + 20;
      bit pv_stall = 0;
      logic [IOW-1:0] prev_data = '0, e;
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(b); length = LW'(len);
      bus.stream_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= bound; cyc++) begin
         bus.stream_ready = rdy(rmode, cyc);
         start = poke && cyc == 3;
         if (start) begin base_addr = AW'($urandom); length = LW'(5); end
         @(negedge clk);
         if (bus.ext_mem_read_en) begin
            check("outstanding", 64'(reads + 1 - hs / PACK <= 2), 64'd1);
            check("read_addr", 64'(bus.ext_mem_read_addr), 64'((b + reads) % H));
            reads++;
         end
         if (bus.stream_valid && first_valid < 0) first_valid = cyc;
         if (pv_stall) begin
            check("stall_valid", 64'(bus.stream_valid), 64'd1);
            check("stall_data", 64'(bus.stream_data), 64'(prev_data));
         end
         if (bus.stream_valid && bus.stream_ready) begin
            e = ref_elem(b, hs);
            check("data", 64'(bus.stream_data), 64'(e));
            check("zero_flag", 64'(bus.stream_zero_flag), 64'(e == '0));
            hs++;
            last_hs = cyc;
            if (hs == len) check("running_last", 64'(running), 64'd1);
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            check("running_at_done", 64'(running), 64'd0);
         end
         pv_stall = bus.stream_valid && !bus.stream_ready;
         prev_data = bus.stream_data;
         if (abort_at >= 0 && hs == abort_at) begin
            arst_n = 1'b0;
            #1;
            check("abort_outputs", {running, done, bus.ext_mem_read_en, bus.ext_mem_read_addr,
                  bus.stream_valid, bus.stream_data, bus.stream_zero_flag}, '0);
            repeat (3) begin
               @(negedge clk);
               check("abort_no_done", 64'({done, running}), 64'd0);
            end
            arst_n = 1'b1;
            return;
         end
         if (done_cyc > 0 && cyc >= done_cyc + 2) break;
         @(posedge clk); #1;
      end
      check("handshakes", 64'(hs), 64'(len));
      check("nreads", 64'(reads), 64'((len + PACK - 1) / PACK));
      check("done_pulses", 64'(dones), 64'd1);
      if (len == 0) check("done_len0", 64'(done_cyc), 64'd1);
      else check("first_valid", 64'(first_valid), 64'd2);
      if (len > 0 && rmode == 0) begin
         check("throughput", 64'(last_hs - first_valid), 64'(len - 1));
         check("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
      end
   endtask
   initial begin
      int b, len;
      bus.stream_ready = 1'b0;
      bus.ext_mem_qout = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {running, done, bus.ext_mem_read_en, bus.ext_mem_read_addr,
            bus.stream_valid, bus.stream_data, bus.stream_zero_flag}, '0);
      @(negedge clk);
      arst_n = 1'b1;
      mem[32'h10] = 32'h0002_0001;
      mem[32'h11] = 32'h0000_0003;
      run_xfer(32'h10, 4, 0, -1, 0);
      run_xfer(32'h10, 3, 0, -1, 0);
      fill(32'h100, 3);  run_xfer(32'h100, 6, 1, -1, 0);
      fill(32'h200, 32); run_xfer(32'h200, 64, 0, -1, 0);
      run_xfer(32'h300, 0, 0, -1, 0);
      fill(H - 1, 2);    run_xfer(H - 1, 4, 0, -1, 0);
      fill(32'h400, 5);  run_xfer(32'h400, 10, 0, -1, 1);
      fill(32'h500, 5);  run_xfer(32'h500, 10, 0, 3, 0);
      fill(32'h600, 4);  run_xfer(32'h600, 7, 2, -1, 0);
      for (int i = 0; i < 8; i++) begin
         b = $urandom_range(H - 1);
         len = $urandom_range(20, 1);
         fill(b, (len + PACK - 1) / PACK);
         run_xfer(b, len, $urandom_range(2), -1, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
